// File: rtl/uart_rx_ctrl.sv
// Receive-side byte buffer between uart_rx and the register block, with interrupt generation.
// Latency: a pushed byte is visible on rd_data_o the next cycle (FWFT head); irq_o lags flags/count by one cycle.
// Backpressure: rx_ready_o follows cfg_en_i only; bytes arriving while full are dropped and flag ovr_o.
// Build option: define UART_RX_TIMEOUT_EN to include the character-timeout FSM and tmo_o.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int TMO_W      = 8,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cfg_en_i,
  input  logic [15:0]      cfg_div_i,
  input  logic [CNT_W-1:0] cfg_thresh_i,
  input  logic [TMO_W-1:0] cfg_tmo_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic             rx_busy_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] fifo_cnt_o,
  output logic             full_o,
  output logic             ovr_o,
  input  logic             ovr_clr_i,
  output logic             tmo_o,
  output logic             irq_o
);

  localparam int PTR_W = CNT_W - 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovr_set;
  logic             ovr_q;
  logic             tmo_q;
  logic             thr_hit;
  logic             irq_q;

  // Ready never depends on fill level so the deserializer cannot stall.
  assign rx_ready_o = cfg_en_i;
  assign full       = (cnt == CNT_W'(FIFO_DEPTH));
  assign empty      = (cnt == '0);
  assign pop        = rd_en_i & ~empty;
  // A full FIFO still accepts a byte when a pop frees the head slot in the same cycle.
  assign push       = rx_valid_i & rx_ready_o & (~full | pop);
  assign ovr_set    = rx_valid_i & rx_ready_o & full & ~pop;

  assign rd_data_o  = empty ? 8'h00 : mem[rd_ptr];
  assign rd_valid_o = ~empty;
  assign fifo_cnt_o = cnt;
  assign full_o     = full;
  assign ovr_o      = ovr_q;
  assign tmo_o      = tmo_q;
  assign irq_o      = irq_q;

  // Byte storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  // Pointers and fill count; disabling the receiver flushes the buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (!cfg_en_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky overrun flag; an explicit clear wins over a new overrun.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_q <= 1'b0;
    end else if (!cfg_en_i || ovr_clr_i) begin
      ovr_q <= 1'b0;
    end else if (ovr_set) begin
      ovr_q <= 1'b1;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  typedef enum logic [1:0] {TMO_IDLE, TMO_RUN, TMO_HIT} tmo_state_t;

  tmo_state_t       tmo_st;
  logic [15:0]      presc;
  logic [15:0]      div_q;
  logic [TMO_W-1:0] bit_cnt;
  logic [TMO_W:0]   bit_nxt;

  assign bit_nxt = (TMO_W+1)'(bit_cnt) + (TMO_W+1)'(1);

  // Character timeout: counts idle bit periods while data waits in the FIFO.
  // div_q is reloaded only at period boundaries so a divisor change takes
  // effect from the next prescaler wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_st  <= TMO_IDLE;
      presc   <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (!cfg_en_i) begin
      tmo_st  <= TMO_IDLE;
      presc   <= '0;
      div_q   <= cfg_div_i;
      bit_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (push || pop) tmo_q <= 1'b0;
      case (tmo_st)
        TMO_IDLE: begin
          presc   <= '0;
          bit_cnt <= '0;
          div_q   <= cfg_div_i;
          if (!empty && !rx_busy_i && (cfg_tmo_i != '0)) tmo_st <= TMO_RUN;
        end
        TMO_RUN: begin
          if (empty || (cfg_tmo_i == '0)) begin
            tmo_st  <= TMO_IDLE;
            presc   <= '0;
            bit_cnt <= '0;
          end else if (push || pop || rx_busy_i) begin
            presc   <= '0;
            bit_cnt <= '0;
            div_q   <= cfg_div_i;
          end else if (presc == div_q) begin
            presc <= '0;
            div_q <= cfg_div_i;
            if (bit_nxt >= {1'b0, cfg_tmo_i}) begin
              tmo_q  <= 1'b1;
              tmo_st <= TMO_HIT;
            end else begin
              bit_cnt <= bit_nxt[TMO_W-1:0];
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        TMO_HIT: begin
          if (push || pop) tmo_st <= TMO_IDLE;
        end
        default: tmo_st <= TMO_IDLE;
      endcase
    end
  end
`else
  logic unused_tmo_inputs;

  assign unused_tmo_inputs = ^{cfg_tmo_i, cfg_div_i, rx_busy_i};
  assign tmo_q             = 1'b0;
`endif

  assign thr_hit = (cfg_thresh_i != '0) && (cnt >= cfg_thresh_i);

  // Registered interrupt from fill threshold and sticky flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_q <= 1'b0;
    end else begin
`ifdef UART_RX_TIMEOUT_EN
      irq_q <= thr_hit | tmo_q | ovr_q;
`else
      irq_q <= thr_hit | ovr_q;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at default parameters (16-entry FIFO).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// The timeout scenario runs only when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [15:0]   cfg_div;
  logic [CW-1:0] cfg_thresh;
  logic [7:0]    cfg_tmo;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_busy;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_cnt;
  logic          full;
  logic          ovr;
  logic          ovr_clr;
  logic          tmo;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TMO_W(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cfg_en_i    (cfg_en),
    .cfg_div_i   (cfg_div),
    .cfg_thresh_i(cfg_thresh),
    .cfg_tmo_i   (cfg_tmo),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .rx_busy_i   (rx_busy),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .fifo_cnt_o  (fifo_cnt),
    .full_o      (full),
    .ovr_o       (ovr),
    .ovr_clr_i   (ovr_clr),
    .tmo_o       (tmo),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic pop_byte(output logic [7:0] b);
    b     = rd_data;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    logic [7:0] d;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (rd_valid) pop_byte(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         k;
    logic       seen;

    rst_n = 1'b0; cfg_en = 1'b1; cfg_div = 16'd9; cfg_thresh = '0; cfg_tmo = 8'd0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_busy = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;

    // Reset values
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_full", full, 0);
    check("rst_ovr", ovr, 0);
    check("rst_tmo", tmo, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_data", rd_data, 8'h00);
    #20 rst_n = 1'b1;
    step();
    check("rx_ready_en", rx_ready, 1);

    // 1: three bytes in order, FWFT head
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    check("t1_cnt3", fifo_cnt, 3);
    check("t1_head41", rd_data, 8'h41);
    pop_byte(d); check("t1_pop41", d, 8'h41);
    check("t1_head42", rd_data, 8'h42);
    check("t1_cnt2", fifo_cnt, 2);
    pop_byte(d); check("t1_pop42", d, 8'h42);
    pop_byte(d); check("t1_pop43", d, 8'h43);
    check("t1_cnt0", fifo_cnt, 0);
    check("t1_valid0", rd_valid, 0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("t1_empty_pop_cnt", fifo_cnt, 0);
    check("t1_empty_rd_data", rd_data, 8'h00);

    // 2: fill to 16, then overrun on the 17th
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    check("t2_full", full, 1);
    check("t2_cnt16", fifo_cnt, 16);
    check("t2_ovr_pre", ovr, 0);
    push_byte(8'hEE);
    check("t2_ovr_set", ovr, 1);
    check("t2_cnt_keep", fifo_cnt, 16);
    check("t2_head_keep", rd_data, 8'h10);
    check("t2_irq_lag", irq, 0);
    step();
    check("t2_irq_set", irq, 1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    check("t2_ovr_clr", ovr, 0);
    check("t2_irq_hold", irq, 1);
    step();
    check("t2_irq_clr", irq, 0);

    // 3: push and pop together while full
    rx_data = 8'hA5; rx_valid = 1'b1; rd_en = 1'b1;
    step();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("t3_cnt16", fifo_cnt, 16);
    check("t3_ovr0", ovr, 0);
    check("t3_full", full, 1);
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(d);
      check("t3_order", d, (i < DEPTH - 1) ? 32'(8'h11 + 8'(i)) : 32'h0A5);
    end
    check("t3_empty", fifo_cnt, 0);

    // 4: fill threshold
    cfg_thresh = 5'd4;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    step();
    check("t4_irq_below", irq, 0);
    push_byte(8'h04);
    check("t4_irq_lag", irq, 0);
    step();
    check("t4_irq_at", irq, 1);
    pop_byte(d);
    check("t4_cnt3", fifo_cnt, 3);
    step();
    check("t4_irq_drop", irq, 0);
    cfg_thresh = '0;
    drain();
    check("t4_drained", fifo_cnt, 0);

`ifdef UART_RX_TIMEOUT_EN
    // 5: character timeout after 4 bit periods of 10 cycles
    cfg_tmo = 8'd4; rx_busy = 1'b1;
    push_byte(8'h55);
    rx_busy = 1'b0;
    k = 0;
    while (!tmo && k < 200) begin step(); k++; end
    check("t5_tmo_cycles", k, 41);
    check("t5_tmo_set", tmo, 1);
    step();
    check("t5_irq_tmo", irq, 1);
    pop_byte(d);
    check("t5_tmo_clr_pop", tmo, 0);
    step();
    check("t5_irq_clr", irq, 0);
    push_byte(8'h66);
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      rx_busy = ((i % 30) == 29);
      step();
      if (tmo) seen = 1'b1;
    end
    rx_busy = 1'b0;
    check("t5_busy_no_tmo", seen, 0);
    cfg_tmo = 8'd0;
    drain();
`else
    // 5: timeout logic absent, tmo_o stays low
    cfg_tmo = 8'd4;
    push_byte(8'h55);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin step(); if (tmo) seen = 1'b1; end
    check("t5_tmo_tied", seen, 0);
    check("t5_irq_none", irq, 0);
    cfg_tmo = 8'd0;
    drain();
`endif

    // 6: disable flushes FIFO and flags
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'h80 + 8'(i));
    for (int i = 0; i < 11; i++) pop_byte(d);
    check("t6_cnt5", fifo_cnt, 5);
    check("t6_ovr1", ovr, 1);
    cfg_en = 1'b0;
    #1;
    check("t6_ready_low", rx_ready, 0);
    step();
    check("t6_cnt0", fifo_cnt, 0);
    check("t6_ovr0", ovr, 0);
    check("t6_valid0", rd_valid, 0);
    check("t6_irq_lag", irq, 1);
    cfg_en = 1'b1;
    step();
    check("t6_irq_fall", irq, 0);
    check("t6_ready_back", rx_ready, 1);

    // 6b: asynchronous reset in the middle of a push
    cfg_thresh = 5'd1;
    push_byte(8'h21); push_byte(8'h22);
    step();
    check("t6_irq_pre_rst", irq, 1);
    rx_data = 8'h77; rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_cnt", fifo_cnt, 0);
    check("t6_arst_valid", rd_valid, 0);
    check("t6_arst_data", rd_data, 8'h00);
    check("t6_arst_full", full, 0);
    check("t6_arst_ovr", ovr, 0);
    check("t6_arst_tmo", tmo, 0);
    check("t6_arst_irq", irq, 0);
    rx_valid = 1'b0; cfg_thresh = '0;
    #3 rst_n = 1'b1;
    step();
    check("t6_post_rst_cnt", fifo_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller between `uart_rx` and the APB register block.
- Accepts bytes from `uart_rx` over its valid/ready handshake and holds `uart_rx` ready so the deserializer never stalls.
- Buffers bytes in an internal FIFO and gives software a first-word-fall-through pop port.
- Generates a fill-level/timeout/overrun interrupt; the character timeout counts in bit periods derived from the shared baud divisor.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; power of two, >= 2.
- TMO_W, 8, width of the timeout threshold in bit periods.
- CNT_W, $clog2(FIFO_DEPTH)+1, derived localparam; width of the fill count.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- cfg_en_i  in  1  receiver enable; low flushes and idles the block.
- cfg_div_i  in  16  baud divisor, same value as fed to `uart_rx`; one bit period = cfg_div_i+1 cycles.
- cfg_thresh_i  in  CNT_W  fill threshold for the interrupt; 0 disables the threshold term.
- cfg_tmo_i  in  TMO_W  idle timeout in bit periods; 0 disables the timeout.
- rx_data_i  in  8  byte from `uart_rx`.
- rx_valid_i  in  1  byte valid from `uart_rx`.
- rx_ready_o  out  1  ready to `uart_rx`.
- rx_busy_i  in  1  `uart_rx` frame in progress.
- rd_en_i  in  1  pop request, one byte per cycle.
- rd_data_o  out  8  FIFO head byte.
- rd_valid_o  out  1  FIFO non-empty.
- fifo_cnt_o  out  CNT_W  current fill level.
- full_o  out  1  fill level == FIFO_DEPTH.
- ovr_o  out  1  sticky overrun flag.
- ovr_clr_i  in  1  clears ovr_o.
- tmo_o  out  1  sticky timeout flag.
- irq_o  out  1  registered interrupt.

Behaviour:
- Reset values: FIFO empty; rd_valid_o=0, fifo_cnt_o=0, full_o=0, ovr_o=0, tmo_o=0, irq_o=0; rd_data_o=8'h00; all counters 0.
- rx_ready_o = cfg_en_i, combinational. Ready is never dropped because the FIFO is full.
- Push: occurs on rx_valid_i & rx_ready_o when not full, or when full with a pop accepted in the same cycle.
- Overrun: when full with no pop, the incoming byte is discarded, FIFO contents are unchanged, and ovr_o is set next cycle.
- Pop: occurs on rd_en_i & rd_valid_o. rd_data_o shows the head combinationally (FWFT); the next entry appears the cycle after a pop. rd_en_i while empty is ignored with no state change.
- Simultaneous push and pop: both are accepted and the count is unchanged, including at full and at count 1.
- Storage: read and write pointers are CNT_W-1 bits and wrap naturally.
- Flags: ovr_clr_i has priority over setting ovr_o. tmo_o clears on any pop or any push.
- Timeout FSM:
  - TMO_IDLE: prescaler and bit counter held at 0. Go to TMO_RUN when the FIFO is non-empty, rx_busy_i=0, and cfg_tmo_i!=0.
  - TMO_RUN: the prescaler counts 0..cfg_div_i; on wrap the bit counter increments. When the bit counter reaches cfg_tmo_i, set tmo_o and go to TMO_HIT.
  - TMO_RUN restart: any push, pop, or rx_busy_i=1 zeroes both counters. Becoming empty or cfg_tmo_i=0 returns to TMO_IDLE.
  - TMO_HIT: hold until a push or pop occurs, then return to TMO_IDLE.
- irq_o is registered from ((cfg_thresh_i!=0) & (fifo_cnt >= cfg_thresh_i)) | tmo_o | ovr_o; one cycle latency from the flag/count update.
- cfg_en_i=0 (synchronous):
  - flush FIFO;
  - clear ovr_o and tmo_o;
  - force TMO_IDLE and zero the counters;
  - rx_ready_o is 0;
  - irq_o falls one cycle later.
- Mid-operation configuration changes: a cfg_div_i change applies from the next prescaler wrap. A cfg_thresh_i change affects irq_o the next cycle.

Optional Feature:
- UART_RX_TIMEOUT_EN defined: timeout FSM, counters, and tmo_o are built as above.
- Undefined: no timeout logic; tmo_o is tied to 0; cfg_tmo_i is ignored; irq_o omits the tmo term.

Test Plan:
1. Push 0x41, 0x42, 0x43, then pop 3: rd_data_o reads 0x41, 0x42, 0x43 in order; fifo_cnt_o goes 3 -> 0; rd_valid_o ends 0.
2. FIFO_DEPTH=16: push 17 bytes without popping -> full_o=1 after the 16th push; the 17th byte is dropped; ovr_o=1 and irq_o=1 one cycle later; ovr_clr_i clears ovr_o.
3. With the FIFO full, assert push and pop in the same cycle -> fifo_cnt_o stays 16; the new byte appears at the tail; ovr_o stays 0.
4. cfg_thresh_i=4: push 3 bytes -> irq_o=0; push a 4th -> irq_o=1 one cycle later; pop 1 -> irq_o=0.
5. UART_RX_TIMEOUT_EN defined, cfg_div_i=9, cfg_tmo_i=4: push 1 byte, then rx_busy_i=0 -> tmo_o=1 about 40 cycles after entering TMO_RUN; pop -> tmo_o=0. Repeat with rx_busy_i pulsing every 30 cycles -> tmo_o never sets.
6. Fill 5 bytes, set ovr_o, deassert cfg_en_i for 1 cycle -> fifo_cnt_o=0, ovr_o=0, rx_ready_o=0 during that cycle. Assert rst_n_i low mid-push -> all outputs return to reset values asynchronously.
